// File: rtl/sa_result_address_writer_pkg.sv
// Shared types and wavefront tables for the systolic-array result write-back path.
package sa_pkg;

    localparam int SA_DIM     = 3;
    localparam int TILE_ELEMS = SA_DIM * SA_DIM;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row and column of each beat as the result tile drains diagonally from the array.
    localparam logic [1:0] WF_ROW [TILE_ELEMS] = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    localparam logic [1:0] WF_COL [TILE_ELEMS] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};

endpackage

// File: rtl/sa_wavefront_index_map.sv
// Maps a drain-order beat index to its (row, col) position inside the result tile.
module sa_wavefront_index_map
    import sa_pkg::*;
(
    input  logic [3:0] idx,
    output logic [1:0] row,
    output logic [1:0] col
);

    // Table lookup; indices past the tile map to the origin.
    always_comb begin
        row = 2'd0;
        col = 2'd0;
        if (idx < 4'(TILE_ELEMS)) begin
            row = WF_ROW[idx];
            col = WF_COL[idx];
        end
    end

endmodule

// File: rtl/sa_result_address_writer.sv
// Tags each result beat with its row-major output-buffer address and writes it out
// through a two-entry FIFO, one 3x3 tile per start pulse.
module sa_result_address_writer
    import sa_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 6,
    parameter int ROW_STRIDE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [3:0]    in_idx_q;
    logic [3:0]    wr_cnt_q;
    logic [AW-1:0] base_q;

    logic [AW-1:0] fifo_addr_p1 [2];
    logic [DW-1:0] fifo_data_p1 [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [1:0]    row;
    logic [1:0]    col;
    logic [AW-1:0] addr_calc;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);

    // in_ready is built from registered state only, so mem_ready never reaches it.
    assign in_ready = (state_q == RUN) && !fifo_full && (in_idx_q < 4'(TILE_ELEMS));
    assign push     = in_valid && in_ready;
    assign pop      = mem_we && mem_ready;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    sa_wavefront_index_map u_map (
        .idx (in_idx_q),
        .row (row),
        .col (col)
    );

    // Address wraps silently modulo 2^AW.
    assign addr_calc = base_q + (AW'(row) * AW'(ROW_STRIDE)) + AW'(col);

    // Head of the FIFO drives the memory port; outputs read zero while empty.
    assign mem_we    = !fifo_empty;
    assign mem_addr  = fifo_empty ? '0 : fifo_addr_p1[rd_ptr_q];
    assign mem_wdata = fifo_empty ? '0 : fifo_data_p1[rd_ptr_q];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: a tile job ends on the ninth accepted write, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pop && (wr_cnt_q == 4'(TILE_ELEMS - 1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job counters and base latch; start is only honoured from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            in_idx_q <= '0;
            wr_cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            base_q   <= base_addr;
            in_idx_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (push) in_idx_q <= in_idx_q + 4'd1;
            if (pop)  wr_cnt_q <= wr_cnt_q + 4'd1;
        end
    end

    // FIFO pointers and occupancy; push while full is blocked by in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---- stage p1: FIFO storage (data only, qualified by count) ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_p1[wr_ptr_q] <= addr_calc;
            fifo_data_p1[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_sa_result_address_writer.sv
// Randomized bench for sa_result_address_writer with a tile-level reference model.
module tb_sa_result_address_writer;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int RS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t       ms = M_IDLE;
    logic [AW-1:0] mbase = '0;
    int            n_acc = 0;
    int            n_wr = 0;
    int            jobs_done = 0;
    logic [DW-1:0] acc_q [$];

    sa_result_address_writer #(.DW(DW), .AW(AW), .ROW_STRIDE(RS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // n-th beat address: walk the anti-diagonals col-row = -2..2, rows ascending within each.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int n);
        int k = 0;
        int sum = 0;
        for (int d = -2; d <= 2; d++) begin
            for (int r = 0; r < 3; r++) begin
                int c = r + d;
                if (c >= 0 && c < 3) begin
                    if (k == n) sum = int'(b) + r * RS + c;
                    k++;
                end
            end
        end
        return AW'(sum);
    endfunction

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        int occ;
        if (!rst_n) begin
            ms    = M_IDLE;
            n_acc = 0;
            n_wr  = 0;
            acc_q.delete();
            chk("rst_outs", {28'd0, in_ready, mem_we, busy, done}, 32'd0);
        end else begin
            occ = n_acc - n_wr;
            chk("busy", 32'(busy), 32'(ms != M_IDLE));
            chk("done", 32'(done), 32'(ms == M_DONE));
            chk("in_ready", 32'(in_ready), 32'(ms == M_RUN && occ < 2 && n_acc < 9));
            chk("mem_we", 32'(mem_we), 32'(occ > 0));
            if (mem_we && occ > 0 && acc_q.size() > 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr(mbase, n_wr)));
                chk("mem_wdata", 32'(mem_wdata), 32'(acc_q[0]));
            end
            case (ms)
                M_IDLE: if (start) begin
                    ms    = M_RUN;
                    mbase = base_addr;
                    n_acc = 0;
                    n_wr  = 0;
                    acc_q.delete();
                end
                M_RUN: begin
                    if (mem_we && mem_ready && acc_q.size() > 0) begin
                        void'(acc_q.pop_front());
                        n_wr++;
                    end
                    if (in_valid && in_ready) begin
                        acc_q.push_back(in_data);
                        n_acc++;
                    end
                    if (n_wr == 9) ms = M_DONE;
                end
                default: begin
                    ms = M_IDLE;
                    jobs_done++;
                end
            endcase
        end
    end

    // One tile job; called and returns just after a rising edge.
    // mode 3: ready stall, 4: start spam mid-job, 5: reset after 5 writes, 6: start in DONE cycle.
    task automatic run_job(input logic [AW-1:0] b, input int vp, input int rp, input int mode);
        int cyc = 0;
        int jd0 = jobs_done;
        bit quit = 1'b0;
        start     = 1'b1;
        base_addr = b;
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        while (!quit && jobs_done == jd0 && cyc < 300) begin
            in_valid  = ($urandom_range(99) < vp);
            in_data   = DW'($urandom);
            mem_ready = ($urandom_range(99) < rp);
            start     = 1'b0;
            if (mode == 3 && cyc >= 3 && cyc < 9) mem_ready = 1'b0;
            if (mode == 4 && cyc == 4) begin start = 1'b1; base_addr = 6'd32; end
            if (mode == 6 && ms == M_DONE) begin start = 1'b1; base_addr = 6'd32; end
            @(posedge clk); #1;
            cyc++;
            if (mode == 5 && n_wr >= 5) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_mem_addr", 32'(mem_addr), 32'd0);
                chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
                @(negedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                quit  = 1'b1;
            end
        end
        if (cyc >= 300) chk("job_timeout", 32'd0, 32'd1);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("por_outs", {28'd0, in_ready, mem_we, busy, done}, 32'd0);
        chk("por_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(6'd0,  100, 100, 0);
        run_job(6'd16, 100, 100, 0);
        run_job(6'd60, 100, 100, 0);
        run_job(6'd8,  100, 100, 3);
        run_job(6'd4,  100, 100, 4);
        run_job(6'd12, 100, 100, 5);
        run_job(6'd0,  100, 100, 0);
        run_job(6'd20, 100, 100, 6);
        run_job(6'd24, 100, 100, 0);
        for (int j = 0; j < 12; j++)
            run_job(AW'($urandom), $urandom_range(30, 100), $urandom_range(30, 100), 0);

        chk("jobs_completed", 32'(jobs_done), 32'd20);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
